// File: rtl/dir_bin_pkg.sv
// Shared types and default sizing for the direction-bin lookup block.
package dir_bin_pkg;

  localparam int unsigned AddrWDefault = 8;
  localparam int unsigned DataWDefault = 5;

  typedef enum logic [1:0] {
    StEmpty,
    StLoading,
    StReady
  } state_e;

endpackage

// File: rtl/dir_bin_table.sv
// Direction-bin table storage: one synchronous write port and one combinational read port.
module dir_bin_table
  import dir_bin_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Contents are not reset; a full load is always required before use.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dir_bin_lut.sv
// Loadable direction-bin lookup table with a 2-stage rotate-and-lookup pipeline.
module dir_bin_lut
  import dir_bin_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_wr_en,
  input  logic [DATA_W-1:0] cfg_wr_data,
  output logic              cfg_busy,
  output logic              tbl_valid,
  input  logic [DATA_W-1:0] rot_offset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_bin
);

  localparam logic [ADDR_W-1:0] CntMax = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CntOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              tbl_we;
  logic [DATA_W-1:0] tbl_rdata;

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_bin_q;
  logic [DATA_W-1:0] s1_off_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_bin_q;
  logic              pipe_en;
  logic              accept;

  dir_bin_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_table (
    .clk_i   (clk),
    .we_i    (tbl_we),
    .waddr_i (cnt_q),
    .wdata_i (cfg_wr_data),
    .raddr_i (in_addr),
    .rdata_o (tbl_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tbl_we  = 1'b0;
    unique case (state_q)
      StEmpty, StReady: begin
        if (cfg_start) begin
          state_d = StLoading;
          cnt_d   = '0;
        end
      end
      StLoading: begin
        // A restart wins over a coincident write, which is dropped.
        if (cfg_start) begin
          cnt_d = '0;
        end else if (cfg_wr_en) begin
          tbl_we = 1'b1;
          cnt_d  = cnt_q + CntOne;
          if (cnt_q == CntMax) begin
            state_d = StReady;
          end
        end
      end
      default: begin
        state_d = StEmpty;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cfg_busy  = (state_q == StLoading);
  assign tbl_valid = (state_q == StReady);

  assign pipe_en  = !out_valid_q || out_ready;
  assign in_ready = (state_q == StReady) && pipe_en;
  assign accept   = in_valid && in_ready;

  // Stage 1 latches the table value so a reload cannot corrupt in-flight requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_bin_q    <= '0;
      s1_off_q    <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
    end else if (pipe_en) begin
      s1_valid_q  <= accept;
      out_valid_q <= s1_valid_q;
      if (accept) begin
        s1_bin_q <= tbl_rdata;
        s1_off_q <= rot_offset;
      end
      if (s1_valid_q) begin
        out_bin_q <= s1_bin_q + s1_off_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;

endmodule
